loop_ctrl: RTL and testbench

- Sequences the program counter for BeeF loop-open and loop-close instructions, which branch on the current data cell.
- Holds an internal return-address stack of loop-open PCs.
- Scans forward with a nesting counter to skip loops whose cell is zero, squashing fetched instructions via bubble during the scan.
- Sits between the instruction mux and the PC source mux/register; replaces ad-hoc branch handling in pc_ctrl.

---
 rtl/loop_ctrl.sv | 146 ++++++++++++++
 tb/tb_loop_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/loop_ctrl.sv
// loop_ctrl: PC sequencing for BeeF loop-open/loop-close with a return stack
// and a forward nesting scan that squashes the instructions of skipped loops.
// Ports: clk, reset (sync, active-high); instruction, pc, cell_zero, stall in;
//        pc_we, pc_src, pc_jump, bubble, depth, fault out.
module loop_ctrl #(
  parameter int            IW       = 9,
  parameter int            PW       = 8,
  parameter int            DEPTH    = 8,
  parameter logic [IW-1:0] OPEN_OP  = 9'h100,
  parameter logic [IW-1:0] CLOSE_OP = 9'h101
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IW-1:0]              instruction,
  input  logic [PW-1:0]              pc,
  input  logic                       cell_zero,
  input  logic                       stall,
  output logic                       pc_we,
  output logic                       pc_src,
  output logic [PW-1:0]              pc_jump,
  output logic                       bubble,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_SCAN,
    S_FLT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [7:0]    nest_q, nest_d;
  logic [PW-1:0] stack_q [DEPTH];
  logic          push;
  logic [AW-1:0] top;
  logic          is_open, is_close;

  assign is_open  = (instruction == OPEN_OP);
  assign is_close = (instruction == CLOSE_OP);
  // Low bits of depth-1 index the top entry, also when the stack is full.
  assign top      = AW'(depth_q - DW'(1));
  assign pc_jump  = (depth_q != '0) ? stack_q[top] + PW'(1) : '0;
  assign depth    = depth_q;

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    nest_d  = nest_q;
    push    = 1'b0;
    pc_we   = 1'b1;
    pc_src  = 1'b0;
    bubble  = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      S_RUN: begin
        unique case (1'b1)
          is_open && !cell_zero: begin
            if (depth_q == DW'(DEPTH)) begin
              pc_we   = 1'b0;
              state_d = S_FLT;
            end else begin
              push    = 1'b1;
              depth_d = depth_q + DW'(1);
            end
          end
          is_open && cell_zero: begin
            nest_d  = 8'd1;
            state_d = S_SCAN;
          end
          is_close: begin
            if (depth_q == '0) begin
              pc_we   = 1'b0;
              state_d = S_FLT;
            end else if (!cell_zero) begin
              pc_src  = 1'b1;
            end else begin
              depth_d = depth_q - DW'(1);
            end
          end
          default: ;
        endcase
      end
      S_SCAN: begin
        bubble = 1'b1;
        if (is_close && nest_q == 8'd1) begin
          nest_d  = 8'd0;
          state_d = S_RUN;
        end else if (pc == '1) begin
          // Scanning off the end of program memory: stop, never wrap.
          pc_we   = 1'b0;
          state_d = S_FLT;
        end else if (is_open) begin
          if (nest_q == 8'd255) begin
            pc_we   = 1'b0;
            state_d = S_FLT;
          end else begin
            nest_d  = nest_q + 8'd1;
          end
        end else if (is_close) begin
          nest_d = nest_q - 8'd1;
        end
      end
      default: begin
        pc_we  = 1'b0;
        bubble = 1'b1;
        fault  = 1'b1;
      end
    endcase
    if (stall) begin
      state_d = state_q;
      depth_d = depth_q;
      nest_d  = nest_q;
      push    = 1'b0;
      pc_we   = 1'b0;
    end
    if (reset) begin
      pc_we  = 1'b0;
      bubble = 1'b1;
      fault  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      depth_q <= '0;
      nest_q  <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      nest_q  <= nest_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack_q[depth_q[AW-1:0]] <= pc;
    end
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// tb_loop_ctrl: directed checks of loop_ctrl with a bench-side PC register.
// Small return stack (4) so overflow is reachable.
module tb_loop_ctrl;

  localparam logic [8:0] OPEN  = 9'h100;
  localparam logic [8:0] CLOSE = 9'h101;
  localparam logic [8:0] NOP   = 9'h003;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] instruction = NOP;
  logic [7:0] pc = '0;
  logic       cell_zero = 1'b0;
  logic       stall = 1'b0;
  logic       pc_we, pc_src, bubble, fault;
  logic [7:0] pc_jump;
  logic [2:0] depth;

  int checks = 0;
  int failures = 0;

  loop_ctrl #(.IW(9), .PW(8), .DEPTH(4), .OPEN_OP(OPEN), .CLOSE_OP(CLOSE)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc(pc),
    .cell_zero(cell_zero), .stall(stall), .pc_we(pc_we), .pc_src(pc_src),
    .pc_jump(pc_jump), .bubble(bubble), .depth(depth), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [8:0] i, input logic cz, input logic st);
    @(negedge clk);
    instruction = i;
    cell_zero   = cz;
    stall       = st;
    #1;
  endtask

  // Clock edge plus the bench's PC register update.
  task automatic tick();
    logic       we, src;
    logic [7:0] j;
    we  = pc_we;
    src = pc_src;
    j   = pc_jump;
    @(posedge clk);
    #1;
    if (we) pc = src ? j : pc + 8'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(NOP, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [8:0] prog2(input logic [7:0] a);
    case (a)
      8'h20, 8'h22: prog2 = OPEN;
      8'h25, 8'h27: prog2 = CLOSE;
      default:      prog2 = NOP;
    endcase
  endfunction

  initial begin
    logic [7:0] held;
    int n;
    // Reset values
    reset = 1'b1;
    set_in(NOP, 1'b0, 1'b0);
    chk("rst_we", pc_we, 0);
    chk("rst_bubble", bubble, 1);
    chk("rst_fault", fault, 0);
    tick();
    reset = 1'b0;
    set_in(NOP, 1'b0, 1'b0);
    chk("run_we", pc_we, 1);
    chk("run_src", pc_src, 0);
    chk("run_bubble", bubble, 0);
    chk("run_depth", depth, 0);
    chk("run_jump", pc_jump, 0);

    // 1. Loop taken
    pc = 8'h10;
    set_in(OPEN, 1'b0, 1'b0);
    tick();
    chk("t1_pc", pc, 8'h11);
    chk("t1_depth", depth, 1);
    pc = 8'h14;
    set_in(CLOSE, 1'b0, 1'b0);
    chk("t1_src", pc_src, 1);
    chk("t1_jump", pc_jump, 8'h11);
    tick();
    chk("t1_back", pc, 8'h11);
    chk("t1_depth2", depth, 1);
    pc = 8'h14;
    set_in(CLOSE, 1'b1, 1'b0);
    chk("t1_src0", pc_src, 0);
    tick();
    chk("t1_exit", pc, 8'h15);
    chk("t1_pop", depth, 0);

    // 2. Nested skip
    pc = 8'h20;
    set_in(prog2(pc), 1'b1, 1'b0);
    chk("t2_open_bub", bubble, 0);
    tick();
    n = 0;
    while (pc != 8'h28 && n < 20) begin
      set_in(prog2(pc), n[0], 1'b0);
      chk("t2_bubble", bubble, 1);
      chk("t2_depth", depth, 0);
      tick();
      n++;
    end
    chk("t2_len", n, 7);
    set_in(NOP, 1'b0, 1'b0);
    chk("t2_pc", pc, 8'h28);
    chk("t2_run_bub", bubble, 0);
    chk("t2_run_we", pc_we, 1);

    // 3. Overflow
    do_reset();
    pc = 8'h40;
    for (int k = 0; k < 4; k++) begin
      set_in(OPEN, 1'b0, 1'b0);
      tick();
    end
    chk("t3_depth", depth, 4);
    chk("t3_jump", pc_jump, 8'h44);
    set_in(OPEN, 1'b0, 1'b0);
    chk("t3_we", pc_we, 0);
    held = pc;
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(NOP, 1'b0, 1'b0);
      chk("t3_fault", fault, 1);
      chk("t3_frz_we", pc_we, 0);
      tick();
      chk("t3_frozen", pc, held);
    end

    // 4. Unmatched close, both cell values
    for (int k = 0; k < 2; k++) begin
      do_reset();
      chk("t4_clear", fault, 0);
      set_in(CLOSE, k[0], 1'b0);
      chk("t4_we0", pc_we, 0);
      tick();
      set_in(NOP, 1'b0, 1'b0);
      chk("t4_fault", fault, 1);
      chk("t4_bubble", bubble, 1);
      chk("t4_we", pc_we, 0);
    end

    // 5. Stall
    do_reset();
    pc = 8'h30;
    set_in(OPEN, 1'b0, 1'b0);
    tick();
    pc = 8'h35;
    for (int k = 0; k < 3; k++) begin
      set_in(CLOSE, 1'b0, 1'b1);
      chk("t5_we", pc_we, 0);
      chk("t5_bub", bubble, 0);
      tick();
      chk("t5_depth", depth, 1);
      chk("t5_pc", pc, 8'h35);
    end
    set_in(CLOSE, 1'b0, 1'b0);
    chk("t5_rel_we", pc_we, 1);
    chk("t5_rel_src", pc_src, 1);
    chk("t5_rel_jump", pc_jump, 8'h31);
    tick();
    chk("t5_rel_pc", pc, 8'h31);

    // 6. Reset mid-scan with nest=2
    do_reset();
    pc = 8'h50;
    set_in(OPEN, 1'b1, 1'b0);
    tick();
    set_in(OPEN, 1'b0, 1'b0);
    chk("t6_scan_bub", bubble, 1);
    tick();
    reset = 1'b1;
    set_in(NOP, 1'b0, 1'b0);
    chk("t6_rst_we", pc_we, 0);
    chk("t6_rst_bub", bubble, 1);
    chk("t6_rst_fault", fault, 0);
    tick();
    reset = 1'b0;
    set_in(NOP, 1'b0, 1'b0);
    chk("t6_bub", bubble, 0);
    chk("t6_we", pc_we, 1);
    chk("t6_depth", depth, 0);
    chk("t6_fault", fault, 0);

    // 7. Scan reaching the last PC without a close
    pc = 8'hFD;
    set_in(OPEN, 1'b1, 1'b0);
    tick();
    set_in(NOP, 1'b0, 1'b0);
    chk("t7_we_fe", pc_we, 1);
    tick();
    chk("t7_pc", pc, 8'hFF);
    set_in(NOP, 1'b0, 1'b0);
    chk("t7_we_ff", pc_we, 0);
    tick();
    set_in(NOP, 1'b0, 1'b0);
    chk("t7_fault", fault, 1);
    chk("t7_hold", pc, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
